// File: rtl/serial_paralelo_rx_pkg.sv
// Shared symbols for the serial link: the idle/alignment
// comma and the receiver FSM state encoding.
package serial_paralelo_rx_pkg;

  localparam logic [7:0] COMMA_SYM = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/serial_paralelo_rx_comma_detect.sv
// Serial shift register, MSB first, with comma match.
// Ports: clk_32f/reset, i_bit in; o_byte_next, o_is_comma out.
module serial_paralelo_rx_comma_detect
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_SYM
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       i_bit,
  output logic [7:0] o_byte_next,
  output logic       o_is_comma
);

  logic [7:0] r_sr;

  // Byte including the bit sampled at the current edge.
  assign o_byte_next = {r_sr[6:0], i_bit};
  assign o_is_comma  = (o_byte_next == COMMA);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_sr <= 8'h00;
    end else begin
      r_sr <= o_byte_next;
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Deserialiser: aligns on commas, then emits non-comma bytes.
// Ports: clk_32f, reset, data_in -> data_out, valid_out, active.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COMMA     = COMMA_SYM,
  parameter int         NUM_COMMA = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] LP_NUM = 4'(NUM_COMMA);

  rx_state_t  r_state;
  rx_state_t  w_state_n;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_n;
  logic [3:0] r_comma_cnt;
  logic [3:0] w_cnt_n;
  logic [7:0] r_data;
  logic [7:0] w_data_n;
  logic       r_valid;
  logic       w_valid_n;
  logic       r_active;
  logic       w_active_n;
  logic [7:0] w_byte_next;
  logic       w_is_comma;
  logic       w_byte_end;
  logic       w_last_comma;

  serial_paralelo_rx_comma_detect #(
    .COMMA (COMMA)
  ) u_det (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .i_bit       (data_in),
    .o_byte_next (w_byte_next),
    .o_is_comma  (w_is_comma)
  );

  assign w_byte_end   = (r_bit_cnt == 3'd7);
  assign w_last_comma = (r_comma_cnt == LP_NUM - 4'd1);

  always_comb begin
    w_state_n  = r_state;
    w_bit_n    = r_bit_cnt;
    w_cnt_n    = r_comma_cnt;
    w_data_n   = r_data;
    w_valid_n  = r_valid;
    w_active_n = r_active;
    unique case (r_state)
      SEARCH: begin
        if (w_is_comma) begin
          w_bit_n = 3'd0;
          w_cnt_n = 4'd1;
          if (NUM_COMMA == 1) begin
            w_state_n  = ACTIVE;
            w_active_n = 1'b1;
          end else begin
            w_state_n = SYNC;
          end
        end
      end
      SYNC: begin
        w_bit_n = r_bit_cnt + 3'd1;
        if (w_byte_end) begin
          if (w_is_comma) begin
            if (r_comma_cnt < LP_NUM) begin
              w_cnt_n = r_comma_cnt + 4'd1;
            end
            if (w_last_comma) begin
              w_state_n  = ACTIVE;
              w_active_n = 1'b1;
            end
          end else begin
            // Hunt restarts on the following edge.
            w_state_n = SEARCH;
            w_cnt_n   = 4'd0;
          end
        end
      end
      ACTIVE: begin
        w_bit_n = r_bit_cnt + 3'd1;
        if (w_byte_end) begin
          if (w_is_comma) begin
            w_valid_n = 1'b0;
          end else begin
            w_data_n  = w_byte_next;
            w_valid_n = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_bit_cnt   <= 3'd0;
      r_comma_cnt <= 4'd0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_bit_n;
      r_comma_cnt <= w_cnt_n;
      r_data      <= w_data_n;
      r_valid     <= w_valid_n;
      r_active    <= w_active_n;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign active    = r_active;

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Receive end of the lane's parallel-to-serial link. It deserialises the 1-bit MSB-first stream clocked by clk_32f into bytes. It acquires byte alignment by hunting for the COMMA symbol (8'hBC) that the transmitter emits while idle. It asserts active once NUM_COMMA consecutive aligned commas are seen, then delivers non-comma bytes to the downstream byte-unstriping logic with a valid flag.

Parameters:
COMMA, 8'hBC, idle/alignment symbol sent by the transmitter while its active is low.
NUM_COMMA, 4, consecutive aligned commas (including the one that achieved alignment) required before active rises; legal range 1..15.

Ports:
clk_32f  input  1  serial bit clock; all state on rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
data_in  input  1  serial bit, MSB of each byte first.
data_out  output  8  last received non-comma byte while active.
valid_out  output  1  high while data_out holds a byte received in the most recent completed byte slot.
active  output  1  link synchronised; sticky until reset.

Behaviour:
- Reset values: data_out=8'h00, valid_out=0, active=0, state=SEARCH, shift register=8'h00, bit_cnt=0, comma_cnt=0.
- Every edge: sr <= {sr[6:0], data_in}; byte_next = {sr[6:0], data_in} is the byte formed by the bit sampled at this edge.
- State SEARCH (bit-level hunt):
  - Checked every edge: if byte_next==COMMA, then bit_cnt<=0 and comma_cnt<=1.
  - On a match, go to ACTIVE if NUM_COMMA==1, otherwise go to SYNC.
  - Outputs are unchanged while in SEARCH.
- Byte boundary: after alignment, bit_cnt increments 0..7 and wraps to 0. The edge with bit_cnt==7 is the byte-complete edge, and byte_next is the received byte.
- State SYNC, at each byte-complete edge:
  - byte_next==COMMA: comma_cnt++. If comma_cnt+1==NUM_COMMA, go to ACTIVE and set active<=1 at that same edge.
  - byte_next!=COMMA: go to SEARCH, comma_cnt<=0. No realignment check is made on this edge; the hunt resumes on the next edge.
- State ACTIVE, at each byte-complete edge:
  - byte_next!=COMMA: data_out<=byte_next, valid_out<=1.
  - byte_next==COMMA: valid_out<=0, data_out holds its value.
  - data_out and valid_out are held constant for the 8 clocks between byte-complete edges.
- ACTIVE has no exit except reset. Misaligned data in ACTIVE is not detected.
- Latency: the output updates at the same edge that samples a byte's LSB, i.e. zero clocks after the last bit.
- With NUM_COMMA=4, active rises exactly 24 clocks after the alignment edge.
- Reset asserted mid-byte or mid-SYNC forces all outputs and state to reset values asynchronously. Reacquisition starts from SEARCH after release.
- Aligned commas in ACTIVE are legal idle and are never forwarded.
- Widths: bit_cnt is 3 bits and wraps naturally. comma_cnt is 4 bits and saturates at NUM_COMMA.

Decomposition:
- Shared package/include holds the COMMA constant (shared with the transmitter) and the state encodings SEARCH=2'd0, SYNC=2'd1, ACTIVE=2'd2.
- One natural sub-module: comma_detect. It contains the 8-bit shift register and exposes byte_next and an is_comma flag. The top holds the FSM and counters.

Test Plan:
1. Reset held, toggle data_in randomly -> data_out=00, valid_out=0, active=0 throughout. Assert reset mid-stream -> all outputs clear within the same time step, with no clock edge needed.
2. Stream BC BC BC BC with 3 random leading bits (misaligned) -> alignment on the LSB of the first BC; active rises on the LSB edge of the 4th BC; valid_out stays 0.
3. After test 2, send 5A, BC, C3 -> data_out=5A with valid_out=1 for 8 clocks, then valid_out=0 with data_out still 5A, then data_out=C3 with valid_out=1.
4. BC BC 77 BC BC BC BC -> return to SEARCH after 77. active rises only on the 7th byte's LSB edge, never earlier.
5. Parameter NUM_COMMA=1, send single BC then 12 -> active on the BC LSB edge; data_out=12, valid_out=1 on the next byte edge.
6. After active, assert reset for 3 clocks mid-byte, release, resend 4×BC then A5 -> full reacquisition, then data_out=A5 with valid_out=1.
